// File: rtl/inst_axi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_axi_responder: fetch-request port to single-beat AXI4 read bridge.
// Rev 1.0
// ---------------------------------------------------------------------------
module inst_axi_responder #(
  parameter int                MAX_OUTSTANDING = 4,
  parameter int                ID_W            = 4,
  parameter logic [ID_W-1:0]   ARID_VAL        = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic            inst_cache,
  input  logic [31:0]     inst_addr,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  output logic            inst_bus_err,
  output logic [3:0]      outstanding,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [3:0]      arcache,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready
);

  localparam logic [3:0] c_max_outstanding = 4'(MAX_OUTSTANDING);

  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [3:0]  r_arcache;
  logic [3:0]  r_outstanding;
  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic        w_accept;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_unused;

  // A single ARID means the interconnect returns beats in issue order,
  // so rid and rlast carry no information here.
  assign w_unused = ^{rid, rlast, rresp[0]};

  assign w_accept = inst_req && (!r_arvalid || arready) &&
                    (r_outstanding < c_max_outstanding);
  assign w_ar_hs  = r_arvalid && arready;
  // Beats arriving with nothing in flight are consumed but not forwarded.
  assign w_r_hs   = rvalid && rready && (r_outstanding != 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arvalid <= 1'b0;
      r_araddr  <= 32'd0;
      r_arcache <= 4'd0;
    end else if (w_accept) begin
      r_arvalid <= 1'b1;
      r_araddr  <= inst_addr;
      r_arcache <= inst_cache ? 4'b1111 : 4'b0000;
    end else if (w_ar_hs) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= 4'd0;
    end else begin
      case ({w_accept, w_r_hs})
        2'b10:   r_outstanding <= r_outstanding + 4'd1;
        2'b01:   r_outstanding <= r_outstanding - 4'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
      r_bus_err <= 1'b0;
    end else begin
      r_data_ok <= w_r_hs;
      if (w_r_hs) begin
        r_rdata   <= rdata;
        r_bus_err <= rresp[1];
      end
    end
  end

  assign inst_addr_ok = w_accept;
  assign inst_data_ok = r_data_ok;
  assign inst_rdata   = r_rdata;
  assign inst_bus_err = r_bus_err;
  assign outstanding  = r_outstanding;
  assign arid         = ARID_VAL;
  assign araddr       = r_araddr;
  assign arlen        = 8'd0;
  assign arsize       = 3'b010;
  assign arburst      = 2'b01;
  assign arcache      = r_arcache;
  assign arvalid      = r_arvalid;
  assign rready       = !reset;

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_inst_axi_responder: randomized bench with queue-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_inst_axi_responder;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic        inst_cache = 1'b0;
  logic [31:0] inst_addr = 32'd0;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        inst_bus_err;
  logic [3:0]  outstanding;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  inst_axi_responder #(.MAX_OUTSTANDING(MAX), .ID_W(4), .ARID_VAL(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_cache(inst_cache), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_bus_err(inst_bus_err),
    .outstanding(outstanding),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arcache(arcache), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: requests waiting for AR, requests awaiting data,
  // and the slave's list of addresses it still owes a beat for.
  logic [32:0] m_arq[$];
  logic [31:0] m_outq[$];
  logic [31:0] slave_q[$];
  int          m_cnt = 0;
  logic        m_dok = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic        m_err = 1'b0;

  int          k_req = 0, k_ar = 100, k_r = 100, k_err = 0;
  bit          k_seq = 1'b1, k_cache_rand = 1'b0, force_spur = 1'b0;
  logic [31:0] next_addr = 32'd0;
  bit          drove_real = 1'b0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h1FC0_0000) return 32'h3C1D_BFC0;
    if (a == 32'h0000_2000) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic drive();
    logic [31:0] tmp;
    inst_req   = ($urandom_range(99) < k_req);
    inst_cache = k_cache_rand ? 1'($urandom_range(1)) : 1'b0;
    tmp        = $urandom();
    inst_addr  = k_seq ? next_addr : {tmp[31:2], 2'b00};
    arready    = ($urandom_range(99) < k_ar);
    rid        = 4'($urandom_range(15));
    rlast      = 1'b1;
    drove_real = 1'b0;
    if (force_spur) begin
      rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b00;
    end else if (slave_q.size() != 0 && $urandom_range(99) < k_r) begin
      rvalid = 1'b1; rdata = mem(slave_q[0]); drove_real = 1'b1;
      if ($urandom_range(99) < k_err) rresp = ($urandom_range(1) == 1) ? 2'b10 : 2'b11;
      else rresp = ($urandom_range(3) == 0) ? 2'b01 : 2'b00;
    end else begin
      rvalid = 1'b0; rdata = $urandom(); rresp = 2'($urandom_range(3));
    end
  endtask

  task automatic evaluate();
    bit exp_acc;
    bit r_counted;
    check_eq("outstanding", 32'(outstanding), 32'(m_cnt));
    check_eq("arvalid", 32'(arvalid), 32'(m_arq.size() != 0));
    if (m_arq.size() != 0) begin
      check_eq("araddr", araddr, m_arq[0][31:0]);
      check_eq("arcache", 32'(arcache), m_arq[0][32] ? 32'hF : 32'h0);
    end
    check_eq("ar_fixed", {arid, arlen, arsize, arburst}, {4'd0, 8'd0, 3'b010, 2'b01});
    check_eq("rready", 32'(rready), 32'd1);
    check_eq("data_ok", 32'(inst_data_ok), 32'(m_dok));
    if (m_dok) begin
      check_eq("rdata", inst_rdata, m_data);
      check_eq("bus_err", 32'(inst_bus_err), 32'(m_err));
    end
    exp_acc = inst_req && (m_arq.size() == 0 || arready) && (m_cnt < MAX);
    check_eq("addr_ok", 32'(inst_addr_ok), 32'(exp_acc));

    r_counted = rvalid && (m_cnt != 0);
    m_dok = r_counted;
    if (r_counted) begin
      m_data = mem(m_outq.pop_front());
      m_err  = rresp[1];
    end
    if (rvalid && drove_real) void'(slave_q.pop_front());
    m_cnt = m_cnt + int'(exp_acc) - int'(r_counted);
    if (m_arq.size() != 0 && arready) slave_q.push_back(m_arq.pop_front()[31:0]);
    if (exp_acc) begin
      m_arq.push_back({inst_cache, inst_addr});
      m_outq.push_back(inst_addr);
      next_addr = next_addr + 32'd4;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      @(negedge clk);
      evaluate();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_arvalid"}, 32'(arvalid), 32'd0);
    check_eq({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    check_eq({tag, "_araddr"}, araddr, 32'd0);
    check_eq({tag, "_arcache"}, 32'(arcache), 32'd0);
    check_eq({tag, "_data_ok"}, 32'(inst_data_ok), 32'd0);
    check_eq({tag, "_rdata"}, inst_rdata, 32'd0);
    check_eq({tag, "_bus_err"}, 32'(inst_bus_err), 32'd0);
    check_eq({tag, "_rready"}, 32'(rready), 32'd0);
  endtask

  initial begin
    #1;
    check_reset_state("por");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Single fetch from the boot vector.
    next_addr = 32'h1FC0_0000; k_req = 100; run_cycles(1);
    k_req = 0; run_cycles(6);

    // Four back-to-back, fifth blocked until the first beat retires.
    next_addr = 32'h0000_1000; k_req = 100; k_r = 0; run_cycles(6);
    check_eq("full_count", 32'(outstanding), 32'd4);
    k_r = 100; run_cycles(6);
    k_req = 0; run_cycles(8);

    // AR channel stall with the request held.
    next_addr = 32'h0000_3000; k_ar = 0; k_req = 100; run_cycles(6);
    k_ar = 100; run_cycles(3);
    k_req = 0; run_cycles(10);

    // Error response.
    next_addr = 32'h0000_2000; k_err = 100; k_req = 100; run_cycles(1);
    k_req = 0; run_cycles(6);
    k_err = 0;

    // Spurious beat with nothing in flight.
    force_spur = 1'b1; run_cycles(1);
    force_spur = 1'b0; run_cycles(2);

    // Three in flight, then asynchronous reset mid-cycle.
    next_addr = 32'h0000_4000; k_r = 0; k_req = 100; run_cycles(3);
    k_req = 0; run_cycles(1);
    check_eq("pre_reset_count", 32'(outstanding), 32'd3);
    inst_req = 1'b0; rvalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_state("async");
    m_arq.delete(); m_outq.delete(); slave_q.delete();
    m_cnt = 0; m_dok = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    k_r = 100; run_cycles(8);

    // Randomized traffic.
    k_seq = 1'b0; k_cache_rand = 1'b1;
    k_req = 60; k_ar = 70; k_r = 50; k_err = 15;
    run_cycles(2000);
    k_req = 0; k_ar = 100; k_r = 100; run_cycles(30);
    check_eq("drained", 32'(outstanding), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_axi_responder.md
Name: inst_axi_responder

Overview:
- Memory-side end of the instruction-fetch request interface (inst_req / inst_addr / inst_cache / inst_addr_ok).
- Accepts fetch requests and issues single-beat AXI4 read bursts.
- Returns fetched words in order on inst_data_ok / inst_rdata.
- Sits between the fetch stage and the AXI crossbar; handles up to MAX_OUTSTANDING in-flight fetches.

Parameters:
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests; power of 2, range 1..8
ARID_VAL, 4'd0, fixed ARID for all fetches; one ID forces in-order return
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request valid
inst_cache  in  1  1 = cacheable attribute for this request
inst_addr  in  32  physical fetch address, word aligned
inst_addr_ok  out  1  request accepted this cycle (combinational)
inst_data_ok  out  1  inst_rdata valid, one pulse per accepted request, in order
inst_rdata  out  32  fetched word
inst_bus_err  out  1  qualifies inst_data_ok: RRESP was SLVERR or DECERR
outstanding  out  4  current in-flight count (debug/perf)
arid  out  ID_W  read address ID = ARID_VAL
araddr  out  32  read address
arlen  out  8  always 0
arsize  out  3  always 3'b010
arburst  out  2  always 2'b01
arcache  out  4  4'b1111 if cacheable, else 4'b0000
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  ID_W  read ID; ignored
rdata  in  32  read data
rresp  in  2  read response
rlast  in  1  ignored; single beat
rvalid  in  1  R valid
rready  out  1  constant 1 when not in reset

Behaviour:
- Reset (async, applies immediately and mid-transaction):
  - arvalid=0, araddr=0, arcache=0, outstanding=0.
  - inst_data_ok=0, inst_rdata=0, inst_bus_err=0, rready=0.
  - In-flight AXI reads are abandoned; any R beats arriving after reset release with outstanding==0 are spurious (see below).
- Acceptance:
  - inst_addr_ok = inst_req && (!arvalid || arready) && (outstanding < MAX_OUTSTANDING).
  - Purely combinational. inst_addr_ok is never high without inst_req.
- AR register:
  - On accept: next cycle arvalid=1, araddr=inst_addr, arcache per inst_cache.
  - Held stable until the arvalid && arready handshake.
  - Handshake with no new accept: arvalid falls to 0 next cycle.
  - Handshake with a new accept in the same cycle: back-to-back, arvalid stays 1 with the new address.
  - Throughput is one request per cycle while arready=1.
- Counter:
  - outstanding +1 on accept; -1 on a counted R handshake (rvalid && rready && outstanding != 0).
  - Both in the same cycle: unchanged.
  - Saturation is impossible because of the acceptance rule.
- Response path:
  - On a counted R handshake, the next cycle drives inst_data_ok=1, inst_rdata=rdata, inst_bus_err=rresp[1].
  - Otherwise inst_data_ok=0 and inst_rdata/inst_bus_err hold their last value.
  - Latency: R handshake -> inst_data_ok is 1 cycle; minimum total request -> data_ok is 3 cycles (accept, AR handshake, R handshake).
- Spurious R beat (rvalid while outstanding==0):
  - Consumed (rready=1); no inst_data_ok; counter stays 0.
- No backpressure to the consumer: the fetch side always accepts inst_data_ok.
- Address alignment:
  - inst_addr[1:0] is passed through unchanged.
  - Alignment exceptions are resolved upstream; misaligned requests never reach this block.

Test Plan:
1. Single fetch: inst_req, inst_addr=0x1FC00000, inst_cache=0; arready=1; rvalid 2 cycles after AR with rdata=0x3C1DBFC0 -> araddr=0x1FC00000, arcache=0, arlen=0, arsize=2; inst_data_ok 1 cycle after the R beat with inst_rdata=0x3C1DBFC0, inst_bus_err=0.
2. Back-to-back with arready=1: addresses 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles -> four consecutive inst_addr_ok; a 5th request waits until the first R beat, with outstanding=4 at that point; data returns in order.
3. AR stall: arready=0 for 5 cycles while inst_req is held -> arvalid high and araddr stable; inst_addr_ok=0 for the second request; the second request is accepted in the cycle arready=1.
4. Error response: rresp=2'b10, rdata=0xDEADBEEF -> inst_data_ok=1, inst_bus_err=1; outstanding decrements.
5. Simultaneous accept and R beat at outstanding=2 -> outstanding stays 2.
6. Spurious rvalid at outstanding=0 -> no inst_data_ok. Then reset asserted with 3 outstanding -> arvalid and outstanding clear immediately (asynchronously), and no data_ok follows.
